// File: rtl/lsu_mem_stage_if.sv
// Data-cache request/response channel between the MEM-stage LSU (master)
// and the data cache (slave).
interface lsu_mem_stage_if;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic        dc_req_we;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_wdata;
  logic [3:0]  dc_req_wstrb;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;

  modport master (
    output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb,
    input  dc_req_ready, dc_resp_valid, dc_resp_rdata
  );

  modport slave (
    input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb,
    output dc_req_ready, dc_resp_valid, dc_resp_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: checks legality, issues one data-cache access,
// stalls the pipeline until the response (or timeout), and returns
// aligned, extended load data to writeback.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  lsu_mem_stage_if.master dc,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  // Counter holds 0..TIMEOUT_CYC-1 WAIT cycles.
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          mem_err_q, mem_err_d;

  logic          op, f3_ok, align_ok, legal;
  logic [31:0]   rsh, ld_ext, st_data;
  logic [3:0]    st_strb;

  // Legality of the op presented by EX; read wins when both flags are set.
  always_comb begin
    op = ex_valid & (ex_mem_read | ex_mem_write);
    if (ex_mem_read)
      f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
    case (ex_funct3[1:0])
      2'b01:   align_ok = ~ex_addr[0];
      2'b10:   align_ok = (ex_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = f3_ok & align_ok;
  end

  // Load lane extraction and store lane replication from the latched op.
  always_comb begin
    rsh = dc.dc_resp_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      3'b100:  ld_ext = {24'd0, rsh[7:0]};
      3'b001:  ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      3'b101:  ld_ext = {16'd0, rsh[15:0]};
      default: ld_ext = dc.dc_resp_rdata;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Request fields are only driven while a request is outstanding.
  assign dc.dc_req_valid = (state_q == S_REQ);
  assign dc.dc_req_we    = (state_q == S_REQ) & we_q;
  assign dc.dc_req_addr  = (state_q == S_REQ) ? {addr_q[31:2], 2'b00} : '0;
  assign dc.dc_req_wdata = (state_q == S_REQ && we_q) ? st_data : '0;
  assign dc.dc_req_wstrb = (state_q == S_REQ && we_q) ? st_strb : '0;

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign mem_err  = mem_err_q;

  // Next-state, operand latch, timeout counter and writeback/error pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mem_err_d  = 1'b0;
    stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (legal) begin
            stall   = 1'b1;
            addr_d  = ex_addr;
            wdata_d = ex_wdata;
            f3_d    = ex_funct3;
            rd_d    = ex_rd;
            we_d    = ~ex_mem_read;
            state_d = S_REQ;
          end else begin
            mem_err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = '0;
        if (dc.dc_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dc.dc_resp_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!we_q && rd_q != 5'd0) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_ext;
          end
        end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

endmodule
